// File: rtl/uart_reg_master_if.sv
// Command/response and register-bus signals of uart_reg_master grouped in one bundle.
// master = the uart_reg_master side, slave = the command source / register file side.
interface uart_reg_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [31:0] cmd_mask;
  logic [31:0] cmd_match;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [5:0]  addr;
  logic        we;
  logic        re;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, cmd_match,
    input  rsp_ready, read_data,
    output cmd_ready, rsp_valid, rsp_data, rsp_err,
    output addr, we, re, write_data
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, cmd_match,
    output rsp_ready, read_data,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err,
    input  addr, we, re, write_data
  );
endinterface

// File: rtl/uart_reg_master.sv
// Register-bus master executing write / read / poll commands with a valid/ready response.
// Optional macro UART_POLL_TIMEOUT_EN: end a poll with rsp_err=1 after POLL_MAX_TRIES misses.
module uart_reg_master #(
  parameter int POLL_GAP       = 4,
  parameter int POLL_MAX_TRIES = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_reg_master_if.master   bus,
  output logic [2:0]          state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and payload is held stable while valid is high.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WRITE     = 3'd1,
    READ      = 3'd2,
    POLL_RD   = 3'd3,
    POLL_WAIT = 3'd4,
    RESP      = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] mask_q, mask_d;
  logic [31:0] match_q, match_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [7:0]  gap_q, gap_d;
  logic        hit;
  logic        bus_phase;

`ifdef UART_POLL_TIMEOUT_EN
  logic [7:0]  tries_q, tries_d;
  logic        rsp_err_q, rsp_err_d;
`endif

  assign hit = ((bus.read_data ^ match_q) & mask_q) == 32'd0;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mask_d     = mask_q;
    match_d    = match_q;
    rsp_data_d = rsp_data_q;
    gap_d      = gap_q;
`ifdef UART_POLL_TIMEOUT_EN
    tries_d    = tries_q;
    rsp_err_d  = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          addr_d     = bus.cmd_addr;
          wdata_d    = bus.cmd_wdata;
          mask_d     = bus.cmd_mask;
          match_d    = bus.cmd_match;
          rsp_data_d = 32'd0;
`ifdef UART_POLL_TIMEOUT_EN
          tries_d    = 8'd0;
          rsp_err_d  = 1'b0;
`endif
          case (bus.cmd_op)
            2'b00:   state_d = WRITE;
            2'b10:   state_d = POLL_RD;
            default: state_d = READ;
          endcase
        end
      end
      WRITE: begin
        rsp_data_d = 32'd0;
        state_d    = RESP;
      end
      READ: begin
        rsp_data_d = bus.read_data;
        state_d    = RESP;
      end
      POLL_RD: begin
        rsp_data_d = bus.read_data;
`ifdef UART_POLL_TIMEOUT_EN
        tries_d    = tries_q + 8'd1;
`endif
        if (hit) begin
          state_d = RESP;
`ifdef UART_POLL_TIMEOUT_EN
        end else if (int'(tries_q) + 1 >= POLL_MAX_TRIES) begin
          rsp_err_d = 1'b1;
          state_d   = RESP;
`endif
        end else if (POLL_GAP == 0) begin
          state_d = POLL_RD;
        end else begin
          // Count down from GAP-1 so POLL_WAIT lasts exactly POLL_GAP cycles.
          gap_d   = 8'(POLL_GAP - 1);
          state_d = POLL_WAIT;
        end
      end
      POLL_WAIT: begin
        if (gap_q == 8'd0) state_d = POLL_RD;
        else               gap_d   = gap_q - 8'd1;
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= 6'd0;
      wdata_q    <= 32'd0;
      mask_q     <= 32'd0;
      match_q    <= 32'd0;
      rsp_data_q <= 32'd0;
      gap_q      <= 8'd0;
`ifdef UART_POLL_TIMEOUT_EN
      tries_q    <= 8'd0;
      rsp_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mask_q     <= mask_d;
      match_q    <= match_d;
      rsp_data_q <= rsp_data_d;
      gap_q      <= gap_d;
`ifdef UART_POLL_TIMEOUT_EN
      tries_q    <= tries_d;
      rsp_err_q  <= rsp_err_d;
`endif
    end
  end

  // All outputs decode registered state only; nothing passes straight through from cmd_* or rsp_ready.
  assign bus_phase      = (state_q == WRITE) || (state_q == READ) || (state_q == POLL_RD);
  assign bus.addr       = bus_phase ? addr_q : 6'd0;
  assign bus.we         = (state_q == WRITE);
  assign bus.re         = (state_q == READ) || (state_q == POLL_RD);
  assign bus.write_data = (state_q == WRITE) ? wdata_q : 32'd0;
  assign bus.cmd_ready  = (state_q == IDLE);
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_data   = rsp_data_q;
`ifdef UART_POLL_TIMEOUT_EN
  assign bus.rsp_err    = rsp_err_q;
`else
  assign bus.rsp_err    = 1'b0;
`endif
  assign state_o        = state_q;

endmodule

// File: tb/tb_uart_reg_master.sv
// Directed bench for uart_reg_master: write, read, poll, stalled response, reset in POLL_WAIT,
// and poll timeout when built with UART_POLL_TIMEOUT_EN.
module tb_uart_reg_master;
  localparam int GAP   = 4;
  localparam int TRIES = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] state;
  logic [31:0] rd_val = 32'd0;
  logic [31:0] late_val = 32'd0;
  int          switch_cnt = 99;

  always #5 clk = ~clk;

  uart_reg_master_if bus();
  assign bus.read_data = rd_val;

  uart_reg_master #(.POLL_GAP(GAP), .POLL_MAX_TRIES(TRIES)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .state_o(state)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  int          re_cnt, we_cnt, rsp_k;
  int          re_k[16];
  logic [5:0]  we_addr, re_addr;
  logic [31:0] we_data;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [5:0] a, input logic [31:0] wd,
                       input logic [31:0] m, input logic [31:0] mt);
    @(negedge clk);
    check("cmd_ready_idle", {31'd0, bus.cmd_ready}, 32'd1);
    bus.cmd_op    = op;
    bus.cmd_addr  = a;
    bus.cmd_wdata = wd;
    bus.cmd_mask  = m;
    bus.cmd_match = mt;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  // k counts negedges after the accepting edge: k=1 is the bus strobe cycle of a write/read.
  task automatic wait_rsp(input int budget);
    bit done = 1'b0;
    re_cnt = 0; we_cnt = 0; rsp_k = 0;
    for (int k = 1; k <= budget && !done; k++) begin
      @(negedge clk);
      if (bus.we || bus.re) check("we_re_excl", {31'd0, bus.we & bus.re}, 32'd0);
      if (bus.we) begin
        we_cnt++;
        we_addr = bus.addr;
        we_data = bus.write_data;
      end
      if (bus.re) begin
        if (re_cnt < 16) re_k[re_cnt] = k;
        re_cnt++;
        re_addr = bus.addr;
      end
      if (!bus.re && re_cnt == switch_cnt) rd_val = late_val;
      if (bus.rsp_valid) begin
        rsp_k = k;
        done  = 1'b1;
        check("resp_bus_idle", {bus.we, bus.re, bus.addr, bus.write_data[23:0]}, 32'd0);
        check("resp_wdata_zero", bus.write_data, 32'd0);
      end
    end
    if (!done) check("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic take_rsp(input int hold, input logic exp_err);
    logic [31:0] d0;
    logic [31:0] e;
    d0 = bus.rsp_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("stall_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("stall_data", bus.rsp_data, d0);
      check("stall_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    end
    check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, exp_err});
    if (exp_q.size() == 0) check("exp_q_empty", 32'd0, 32'd1);
    else begin
      e = exp_q.pop_front();
      check("rsp_data", bus.rsp_data, e);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
    check("back_idle", {29'd0, state}, 32'd0);
    check("rsp_valid_low", {31'd0, bus.rsp_valid}, 32'd0);
    check("cmd_ready_high", {31'd0, bus.cmd_ready}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we_re"}, {30'd0, bus.we, bus.re}, 32'd0);
    check({tag, "_addr"}, {26'd0, bus.addr}, 32'd0);
    check({tag, "_wdata"}, bus.write_data, 32'd0);
    check({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
    check({tag, "_rsp_data"}, bus.rsp_data, 32'd0);
    check({tag, "_rsp_err"}, {31'd0, bus.rsp_err}, 32'd0);
    check({tag, "_state"}, {29'd0, state}, 32'd0);
  endtask

  initial begin
    int seen;
    bit got;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_addr  = 6'd0;
    bus.cmd_wdata = 32'd0;
    bus.cmd_mask  = 32'd0;
    bus.cmd_match = 32'd0;
    bus.rsp_ready = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);

    // Write 0x04 <= 0x00001234
    issue(2'b00, 6'h04, 32'h0000_1234, 32'd0, 32'd0);
    exp_q.push_back(32'd0);
    wait_rsp(8);
    check("wr_we_pulses", we_cnt, 1);
    check("wr_re_pulses", re_cnt, 0);
    check("wr_addr", {26'd0, we_addr}, 32'h04);
    check("wr_data", we_data, 32'h0000_1234);
    check("wr_latency", rsp_k, 2);
    take_rsp(0, 1'b0);

    // Read 0x08 -> 0xA5
    rd_val = 32'h0000_00A5;
    issue(2'b01, 6'h08, 32'hFFFF_FFFF, 32'd0, 32'd0);
    exp_q.push_back(32'h0000_00A5);
    wait_rsp(8);
    check("rd_re_pulses", re_cnt, 1);
    check("rd_we_pulses", we_cnt, 0);
    check("rd_addr", {26'd0, re_addr}, 32'h08);
    check("rd_latency", rsp_k, 2);
    take_rsp(0, 1'b0);

    // Poll bit0, set after the 2nd read so the 3rd read matches
    rd_val = 32'hFFFF_FFFE; late_val = 32'h0000_0001; switch_cnt = 2;
    issue(2'b10, 6'h10, 32'd0, 32'h1, 32'h1);
    exp_q.push_back(32'h0000_0001);
    wait_rsp(60);
    switch_cnt = 99;
    check("poll_re_pulses", re_cnt, 3);
    check("poll_first_re", re_k[0], 1);
    check("poll_gap_1", re_k[1] - re_k[0], GAP + 1);
    check("poll_gap_2", re_k[2] - re_k[1], GAP + 1);
    check("poll_rsp_k", rsp_k, re_k[2] + 1);
    take_rsp(0, 1'b0);

    // Reserved op behaves as read; response stalled for 10 cycles
    rd_val = 32'hDEAD_BEEF;
    issue(2'b11, 6'h3F, 32'd0, 32'd0, 32'd0);
    exp_q.push_back(32'hDEAD_BEEF);
    wait_rsp(8);
    check("rsvd_re_pulses", re_cnt, 1);
    check("rsvd_addr", {26'd0, re_addr}, 32'h3F);
    take_rsp(10, 1'b0);

`ifdef UART_POLL_TIMEOUT_EN
    rd_val = 32'h0000_0022;
    issue(2'b10, 6'h11, 32'd0, 32'h1, 32'h1);
    exp_q.push_back(32'h0000_0022);
    wait_rsp(60);
    check("to_re_pulses", re_cnt, TRIES);
    take_rsp(0, 1'b1);
`endif

    // Reset while the poll sits in POLL_WAIT
    rd_val = 32'd0;
    issue(2'b10, 6'h12, 32'd0, 32'h1, 32'h1);
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (bus.re) got = 1'b1;
    end
    check("rst_first_re_seen", {31'd0, got}, 32'd1);
    repeat (2) @(negedge clk);
    check("rst_in_poll_wait", {29'd0, state}, 32'd4);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.re) seen++;
    end
    check("rst_no_re_after", seen, 0);
    check("rst_idle_after", {29'd0, state}, 32'd0);

    issue(2'b00, 6'h2A, 32'h0000_CAFE, 32'd0, 32'd0);
    exp_q.push_back(32'd0);
    wait_rsp(8);
    check("post_rst_we_pulses", we_cnt, 1);
    check("post_rst_addr", {26'd0, we_addr}, 32'h2A);
    check("post_rst_data", we_data, 32'h0000_CAFE);
    check("post_rst_latency", rsp_k, 2);
    take_rsp(0, 1'b0);

    check("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/uart_reg_master.md
UART_REG_MASTER -- requirements
Module: uart_reg_master

Interface
REQ-001 SHALL have parameter POLL_GAP, default 4, idle cycles between successive poll reads (0..255).
REQ-002 SHALL have parameter POLL_MAX_TRIES, default 255, maximum poll reads before timeout (1..255).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when high together with cmd_valid.
REQ-007 SHALL have port cmd_op  input  2  00 write, 01 read, 10 poll, 11 reserved (treated as read).
REQ-008 SHALL have port cmd_addr  input  6  target register address.
REQ-009 SHALL have port cmd_wdata  input  32  write data (write op).
REQ-010 SHALL have port cmd_mask  input  32  poll compare mask.
REQ-011 SHALL have port cmd_match  input  32  poll compare value.
REQ-012 SHALL have port rsp_valid  output  1  response available.
REQ-013 SHALL have port rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-014 SHALL have port rsp_data  output  32  read/poll result; 0 for writes.
REQ-015 SHALL have port rsp_err  output  1  poll timeout flag.
REQ-016 SHALL have port addr  output  6  register-bus address.
REQ-017 SHALL have port we  output  1  register-bus write strobe.
REQ-018 SHALL have port re  output  1  register-bus read strobe.
REQ-019 SHALL have port write_data  output  32  register-bus write data.
REQ-020 SHALL have port read_data  input  32  register-bus read data, combinationally valid in the cycle re is high.

Function
REQ-021 SHALL implement states IDLE, WRITE, READ, POLL_RD, POLL_WAIT, RESP.
REQ-022 SHALL drive cmd_ready=1 only in IDLE; on cmd_valid&&cmd_ready latch cmd_op/addr/wdata/mask/match and enter WRITE, READ or POLL_RD next cycle.
REQ-023 SHALL derive addr, we, re, write_data, cmd_ready, rsp_* only from registered state/latched fields, with no combinational path from cmd_* or rsp_ready.
REQ-024 SHALL in WRITE assert we=1, re=0 for exactly one cycle with addr/write_data = latched values, then enter RESP with rsp_data=0, rsp_err=0.
REQ-025 SHALL in READ assert re=1, we=0 for exactly one cycle, capture read_data at that cycle's closing edge into rsp_data, then enter RESP.
REQ-026 SHALL in POLL_RD assert re=1 for one cycle, capture read_data, increment try counter; if (read_data & mask)==(match & mask) enter RESP with rsp_err=0.
REQ-027 SHALL on poll mismatch enter POLL_WAIT for POLL_GAP cycles (we=re=0) then POLL_RD; with POLL_GAP=0 go directly POLL_RD to POLL_RD (back-to-back reads).
REQ-028 SHALL in RESP hold rsp_valid=1 and rsp_data/rsp_err stable until rsp_ready=1, then return to IDLE next cycle; no new command accepted in RESP.
REQ-029 SHALL drive addr=0 and write_data=0 and we=re=0 outside WRITE/READ/POLL_RD.
REQ-030 SHALL never assert we and re in the same cycle.
REQ-031 SHALL give latency: accept at edge N, bus strobe in cycle N+1, rsp_valid from cycle N+2 (write/read).

Reset
REQ-032 SHALL on rst_n=0 immediately force IDLE, cmd_ready=1 after release, rsp_valid=0, rsp_data=0, rsp_err=0, addr=0, we=0, re=0, write_data=0, counters=0, discarding any in-flight command.

Configuration
REQ-033 SHALL with macro UART_POLL_TIMEOUT_EN defined end a poll with rsp_err=1 and rsp_data=last read value after POLL_MAX_TRIES mismatching reads (no further POLL_WAIT).
REQ-034 SHALL with UART_POLL_TIMEOUT_EN undefined poll indefinitely, omit the try counter, and tie rsp_err=0.

Verification
REQ-035 SHALL cover: write addr 0x04 data 0x00001234 -> one cycle we=1, addr=0x04, write_data=0x00001234; rsp_valid at N+2, rsp_data=0.
REQ-036 SHALL cover: read addr 0x08 with read_data=0x000000A5 -> one re pulse, rsp_data=0x000000A5, rsp_err=0.
REQ-037 SHALL cover: poll mask 0x1 match 0x1, read_data bit0 set before 3rd read -> exactly 3 re pulses separated by 4 idle cycles, rsp_err=0.
REQ-038 SHALL cover (UART_POLL_TIMEOUT_EN, POLL_MAX_TRIES=3): never matching -> 3 re pulses then rsp_err=1, rsp_data=last read_data.
REQ-039 SHALL cover: rsp_ready held low 10 cycles -> rsp_valid and rsp_data stable, cmd_ready=0 throughout, IDLE one cycle after rsp_ready=1.
REQ-040 SHALL cover: rst_n pulsed low during POLL_WAIT -> all outputs at reset values immediately, no further re pulse, next command executes normally.
